// File: rtl/rv32i_types.sv
// Shared types for the instruction-memory responder.
// Holds the response-queue entry layout and the RV32I canonical NOP word.
package rv32i_types;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned WIDX_W = XLEN - 2;  // word offset from BASE
   localparam int unsigned CNT_W  = 3;         // countdown, covers LATENCY-1 up to 6

   localparam logic [XLEN-1:0] NOP = 32'h00000013;  // addi x0, x0, 0

   // One outstanding request waiting for its response slot.
   typedef struct packed {
      logic [WIDX_W-1:0] widx;       // (addr - BASE) >> 2
      logic              range_err;  // address outside the backing store
      logic              misalign;   // addr[1:0] != 0
      logic [CNT_W-1:0]  cnt;        // cycles left before the response
   } imem_qentry_t;

endpackage

// File: rtl/imem_responder_if.sv
// Instruction-fetch request/response bus.
//   imem_addr  : request byte address (master -> slave)
//   imem_rmask : read strobe, any nonzero value is a request (master -> slave)
//   imem_rdata : response word, meaningful only with imem_resp (slave -> master)
//   imem_resp  : one-cycle response pulse (slave -> master)
interface imem_responder_if;
   import rv32i_types::*;

   logic [XLEN-1:0] imem_addr;
   logic [3:0]      imem_rmask;
   logic [XLEN-1:0] imem_rdata;
   logic            imem_resp;

   modport master (output imem_addr, output imem_rmask,
                   input  imem_rdata, input  imem_resp);

   modport slave  (input  imem_addr, input  imem_rmask,
                   output imem_rdata, output imem_resp);

endinterface

// File: rtl/imem_resp_queue.sv
// In-order queue of outstanding fetch requests with per-entry countdowns.
//   clk, rst   : clock, asynchronous active-high reset
//   push_i     : request this cycle (ignored when full without a pop)
//   entry_i    : entry to enqueue, countdown already loaded
//   pop_c_o    : head countdown reached zero, head is retired this cycle
//   full_c_o   : occupancy equals QDEPTH
//   empty_c_o  : occupancy is zero
//   head_c_o   : current head entry
// QDEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module imem_resp_queue
   import rv32i_types::*;
#(
   parameter int unsigned QDEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  imem_qentry_t entry_i,
   output logic         pop_c_o,
   output logic         full_c_o,
   output logic         empty_c_o,
   output imem_qentry_t head_c_o
);

   localparam int unsigned PW = $clog2(QDEPTH);
   localparam int unsigned CW = PW + 1;

   imem_qentry_t   q_q [QDEPTH];
   imem_qentry_t   q_d [QDEPTH];
   logic [PW-1:0]  head_q, head_d;
   logic [PW-1:0]  tail_q, tail_d;
   logic [CW-1:0]  count_q, count_d;
   logic           push_ok_c;

   // Next-state: age every entry, retire a ripe head, append a new request.
   always_comb begin
      q_d       = q_q;
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;

      empty_c_o = (count_q == '0);
      full_c_o  = (count_q == CW'(QDEPTH));
      pop_c_o   = !empty_c_o && (q_q[head_q].cnt == '0);
      // A full queue still accepts when the head leaves in the same cycle.
      push_ok_c = push_i && (!full_c_o || pop_c_o);

      foreach (q_d[i]) begin
         if (q_q[i].cnt != '0) q_d[i].cnt = q_q[i].cnt - CNT_W'(1);
      end

      if (pop_c_o) head_d = head_q + PW'(1);

      // On full+pop the tail slot is the head slot; the head is read from q_q.
      if (push_ok_c) begin
         q_d[tail_q] = entry_i;
         tail_d      = tail_q + PW'(1);
      end

      case ({push_ok_c, pop_c_o})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   assign head_c_o = q_q[head_q];

   // Queue state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q     <= '{default: '0};
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         q_q     <= q_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/imem_responder.sv
// Fixed-latency instruction-memory model for a fetch unit.
//   clk, rst         : clock, asynchronous active-high reset
//   bus              : imem request/response bus (slave side)
//   load_we          : preload write enable
//   load_addr        : preload byte address, writes outside the window are dropped
//   load_data        : preload word
//   err_overflow     : sticky, a request was dropped because the queue was full
//   err_range        : sticky, a request fell outside [BASE, BASE+4*DEPTH)
//   err_misaligned   : sticky, a request had imem_addr[1:0] != 0
// A request sampled on edge t is answered by a registered pulse after edge t+LATENCY.
module imem_responder
   import rv32i_types::*;
#(
   parameter logic [XLEN-1:0] BASE    = 32'h1eceb000,
   parameter int unsigned     DEPTH   = 256,
   parameter int unsigned     LATENCY = 2,
   parameter int unsigned     QDEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   imem_responder_if.slave   bus,
   input  logic              load_we,
   input  logic [XLEN-1:0]   load_addr,
   input  logic [XLEN-1:0]   load_data,
   output logic              err_overflow,
   output logic              err_range,
   output logic              err_misaligned
);

   localparam int unsigned     AW     = $clog2(DEPTH);
   localparam logic [XLEN-1:0] WINDOW = XLEN'(DEPTH) << 2;

   logic [XLEN-1:0] mem_q [DEPTH];

   logic            req_c;
   logic [XLEN-1:0] req_off_c;
   imem_qentry_t    entry_c;
   logic            pop_c, full_c, empty_c;
   imem_qentry_t    head_c;
   logic [XLEN-1:0] load_off_c;
   logic            load_in_win_c;
   logic [AW-1:0]   load_idx_c;
   logic [XLEN-1:0] rsp_word_c;
   logic            unused_c;

   logic            resp_q, resp_d;
   logic [XLEN-1:0] rdata_q, rdata_d;
   logic            ovf_q, ovf_d;
   logic            rng_q, rng_d;
   logic            mis_q, mis_d;

   // Request decode into a queue entry.
   always_comb begin
      req_c             = |bus.imem_rmask;
      req_off_c         = bus.imem_addr - BASE;
      entry_c.widx      = WIDX_W'(req_off_c >> 2);
      // Addresses below BASE wrap to large offsets and fail this compare too.
      entry_c.range_err = !(req_off_c < WINDOW);
      entry_c.misalign  = (bus.imem_addr[1:0] != 2'b00);
      entry_c.cnt       = CNT_W'(LATENCY - 1);
   end

   imem_resp_queue #(
      .QDEPTH (QDEPTH)
   ) u_queue (
      .clk       (clk),
      .rst       (rst),
      .push_i    (req_c),
      .entry_i   (entry_c),
      .pop_c_o   (pop_c),
      .full_c_o  (full_c),
      .empty_c_o (empty_c),
      .head_c_o  (head_c)
   );

   // Preload address decode.
   always_comb begin
      load_off_c    = load_addr - BASE;
      load_in_win_c = (load_off_c < WINDOW);
      load_idx_c    = AW'(load_off_c >> 2);
   end

   // Backing store; not reset, read at response time so a same-edge write returns old data.
   always_ff @(posedge clk) begin
      if (load_we && load_in_win_c) mem_q[load_idx_c] <= load_data;
   end

   // Response word selection and next state for response/error registers.
   always_comb begin
      rsp_word_c = mem_q[head_c.widx[AW-1:0]];
      resp_d     = pop_c;
      rdata_d    = rdata_q;
      ovf_d      = ovf_q | (req_c && full_c && !pop_c);
      rng_d      = rng_q | (req_c && entry_c.range_err);
      mis_d      = mis_q | (req_c && entry_c.misalign);

      if (pop_c) begin
         if (head_c.misalign)       rdata_d = '0;
         else if (head_c.range_err) rdata_d = NOP;
         else                       rdata_d = rsp_word_c;
      end
   end

   // Response and sticky error registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_q  <= 1'b0;
         rdata_q <= '0;
         ovf_q   <= 1'b0;
         rng_q   <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         resp_q  <= resp_d;
         rdata_q <= rdata_d;
         ovf_q   <= ovf_d;
         rng_q   <= rng_d;
         mis_q   <= mis_d;
      end
   end

   assign bus.imem_resp  = resp_q;
   assign bus.imem_rdata = rdata_q;
   assign err_overflow   = ovf_q;
   assign err_range      = rng_q;
   assign err_misaligned = mis_q;

   // Head countdown and upper offset bits are not needed at the top.
   assign unused_c = ^{empty_c, head_c.cnt, head_c.widx};

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: dut1 uses LATENCY=2, dut2 uses LATENCY=7.
module tb_imem_responder;
   import rv32i_types::*;

   localparam logic [31:0] BASE = 32'h1eceb000;
   localparam int          L1   = 2;
   localparam int          L2   = 7;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load_we;
   logic [31:0] load_addr, load_data;
   logic        ovf1, rng1, mis1, ovf2, rng2, mis2;

   int          cyc = 0;
   int          checks = 0;
   int          passes = 0;
   exp_t        q1[$];
   exp_t        q2[$];
   exp_t        e1, e2;
   logic [31:0] last1, last2;

   imem_responder_if bus1();
   imem_responder_if bus2();

   imem_responder #(.LATENCY(L1)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1),
      .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
      .err_overflow(ovf1), .err_range(rng1), .err_misaligned(mis1)
   );

   imem_responder #(.LATENCY(L2)) dut2 (
      .clk(clk), .rst(rst), .bus(bus2),
      .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
      .err_overflow(ovf2), .err_range(rng2), .err_misaligned(mis2)
   );

   always #5 clk = ~clk;

   // Number of rising edges so far; stable at every falling edge.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Present one request at a falling edge; it is sampled on the next rising edge.
   task automatic issue(input int which, input logic [31:0] addr,
                        input logic [31:0] data, input bit acc);
      exp_t e;
      e.data = data;
      if (which == 1) begin
         bus1.imem_addr  = addr;
         bus1.imem_rmask = 4'hf;
         e.cyc = cyc + 1 + L1;
         if (acc) q1.push_back(e);
      end else begin
         bus2.imem_addr  = addr;
         bus2.imem_rmask = 4'hf;
         e.cyc = cyc + 1 + L2;
         if (acc) q2.push_back(e);
      end
      @(negedge clk);
      bus1.imem_rmask = 4'h0;
      bus2.imem_rmask = 4'h0;
   endtask

   task automatic load(input logic [31:0] addr, input logic [31:0] data);
      load_we   = 1'b1;
      load_addr = addr;
      load_data = data;
      @(negedge clk);
      load_we   = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor dut1: every pulse must match the scoreboard head in data and cycle.
   always @(negedge clk) begin
      if (rst) last1 = '0;
      else if (bus1.imem_resp) begin
         if (q1.size() == 0) begin
            checks++;
            $display("FAIL d1_unexpected_resp: rdata=%h at cycle %0d, none expected",
                     bus1.imem_rdata, cyc);
         end else begin
            e1 = q1.pop_front();
            check("d1_rdata", bus1.imem_rdata, e1.data);
            check("d1_resp_cycle", 32'(cyc), 32'(e1.cyc));
         end
         last1 = bus1.imem_rdata;
      end else check("d1_rdata_hold", bus1.imem_rdata, last1);
   end

   // Monitor dut2.
   always @(negedge clk) begin
      if (rst) last2 = '0;
      else if (bus2.imem_resp) begin
         if (q2.size() == 0) begin
            checks++;
            $display("FAIL d2_unexpected_resp: rdata=%h at cycle %0d, none expected",
                     bus2.imem_rdata, cyc);
         end else begin
            e2 = q2.pop_front();
            check("d2_rdata", bus2.imem_rdata, e2.data);
            check("d2_resp_cycle", 32'(cyc), 32'(e2.cyc));
         end
         last2 = bus2.imem_rdata;
      end else check("d2_rdata_hold", bus2.imem_rdata, last2);
   end

   initial begin
      bus1.imem_addr  = '0;
      bus1.imem_rmask = 4'h0;
      bus2.imem_addr  = '0;
      bus2.imem_rmask = 4'h0;
      load_we   = 1'b0;
      load_addr = '0;
      load_data = '0;

      repeat (3) @(negedge clk);
      check("rst_resp1",  32'(bus1.imem_resp), 32'd0);
      check("rst_rdata1", bus1.imem_rdata, 32'd0);
      check("rst_ovf1",   32'(ovf1), 32'd0);
      check("rst_rng1",   32'(rng1), 32'd0);
      check("rst_mis1",   32'(mis1), 32'd0);
      check("rst_resp2",  32'(bus2.imem_resp), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      load(BASE,        32'hdeadbeef);
      load(BASE + 4,    32'h11111111);
      load(BASE + 8,    32'h22222222);
      load(BASE + 12,   32'h00000002);
      load(BASE + 1020, 32'h00000055);
      load(BASE + 1024, 32'hcafef00d);  // one past the window, must not alias word 0
      load(BASE - 4,    32'h0badf00d);
      idle(2);

      // Single request, response exactly LATENCY edges later.
      issue(1, BASE, 32'hdeadbeef, 1'b1);
      idle(4);

      // Back-to-back burst.
      issue(1, BASE,     32'hdeadbeef, 1'b1);
      issue(1, BASE + 4, 32'h11111111, 1'b1);
      issue(1, BASE + 8, 32'h22222222, 1'b1);
      idle(4);

      // Range and alignment handling.
      check("rng1_clear", 32'(rng1), 32'd0);
      issue(1, 32'h1ecea000, NOP, 1'b1);
      idle(4);
      check("rng1_set", 32'(rng1), 32'd1);
      check("mis1_clear", 32'(mis1), 32'd0);
      issue(1, BASE + 1020, 32'h00000055, 1'b1);
      issue(1, BASE + 1024, NOP, 1'b1);
      idle(4);
      issue(1, 32'h1eceb002, 32'h00000000, 1'b1);
      idle(4);
      check("mis1_set", 32'(mis1), 32'd1);
      check("rng1_sticky", 32'(rng1), 32'd1);
      check("ovf1_clear", 32'(ovf1), 32'd0);

      // Write to word 3 on the same edge its response is formed: old data returns.
      issue(1, BASE + 12, 32'h00000002, 1'b1);
      @(negedge clk);
      load_we   = 1'b1;
      load_addr = BASE + 12;
      load_data = 32'h00000001;
      @(negedge clk);
      load_we   = 1'b0;
      idle(3);
      issue(1, BASE + 12, 32'h00000001, 1'b1);
      idle(4);

      // Asynchronous reset with two requests in flight.
      issue(1, BASE,     32'hdeadbeef, 1'b0);
      issue(1, BASE + 4, 32'h11111111, 1'b0);
      @(posedge clk);
      #1;
      check("pre_rst_resp1", 32'(bus1.imem_resp), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      check("async_rst_resp1",  32'(bus1.imem_resp), 32'd0);
      check("async_rst_rdata1", bus1.imem_rdata, 32'd0);
      check("async_rst_rng1",   32'(rng1), 32'd0);
      check("async_rst_mis1",   32'(mis1), 32'd0);
      check("async_rst_ovf1",   32'(ovf1), 32'd0);
      bus1.imem_addr  = BASE;
      bus1.imem_rmask = 4'hf;  // ignored while in reset
      repeat (3) @(negedge clk);
      rst = 1'b0;
      bus1.imem_rmask = 4'h0;
      idle(10);
      issue(1, BASE, 32'hdeadbeef, 1'b1);  // store survives reset
      idle(4);

      // Overflow on the LATENCY=7 instance.
      check("ovf2_clear", 32'(ovf2), 32'd0);
      issue(2, BASE,      32'hdeadbeef, 1'b1);
      issue(2, BASE + 4,  32'h11111111, 1'b1);
      issue(2, BASE + 8,  32'h22222222, 1'b1);
      issue(2, BASE + 12, 32'h00000001, 1'b1);
      issue(2, BASE,      32'hdeadbeef, 1'b0);
      issue(2, BASE + 4,  32'h11111111, 1'b0);
      check("ovf2_set", 32'(ovf2), 32'd1);
      check("ovf1_untouched", 32'(ovf1), 32'd0);
      @(negedge clk);
      // Sampled on the edge the first entry retires: full but accepted.
      issue(2, BASE + 8, 32'h22222222, 1'b1);
      idle(20);

      check("sb1_drained", 32'(q1.size()), 32'd0);
      check("sb2_drained", 32'(q2.size()), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter BASE, default 32'h1eceb000, byte address of word 0 of the backing store.
REQ-002 Parameter DEPTH, default 256, backing-store size in 32-bit words (power of two).
REQ-003 Parameter LATENCY, default 2, request-to-response cycles (legal 1..7).
REQ-004 Parameter QDEPTH, default 4, max outstanding requests (power of two).
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 imem_addr  in  32  request byte address, sampled when imem_rmask != 0.
REQ-008 imem_rmask  in  4  request strobe; any nonzero value is a read request.
REQ-009 imem_rdata  out  32  response instruction word, valid only with imem_resp.
REQ-010 imem_resp  out  1  one-cycle response pulse.
REQ-011 load_we  in  1  backing-store preload write enable.
REQ-012 load_addr  in  32  preload byte address (word-aligned, inside window).
REQ-013 load_data  in  32  preload word.
REQ-014 err_overflow  out  1  sticky: request dropped because queue full.
REQ-015 err_range  out  1  sticky: request outside [BASE, BASE+4*DEPTH).
REQ-016 err_misaligned  out  1  sticky: request with imem_addr[1:0] != 0.

Function
REQ-017 Accepted request SHALL push {word index, range flag, misalign flag, countdown=LATENCY-1} into an in-order queue.
REQ-018 Request issued in cycle t SHALL produce imem_resp=1 in cycle t+LATENCY; imem_rdata/imem_resp SHALL be registered.
REQ-019 Back-to-back requests every cycle SHALL yield back-to-back responses with LATENCY spacing preserved and original order.
REQ-020 All queued countdowns SHALL decrement each cycle, saturating at 0; head entry at countdown 0 SHALL be popped and responded.
REQ-021 Queue full with no pop that cycle: request SHALL be dropped and err_overflow set; full with simultaneous pop: request SHALL be accepted.
REQ-022 Response data: in-range aligned -> mem[(addr-BASE)>>2]; out of range -> 32'h00000013; misaligned -> 32'h00000000.
REQ-023 Array SHALL be read at response time; load_we write to same word in the response cycle SHALL return old data.
REQ-024 load_we SHALL write mem[(load_addr-BASE)>>2]; out-of-window load_addr SHALL be ignored.
REQ-025 Occupancy counter SHALL be log2(QDEPTH)+1 bits; head/tail pointers SHALL wrap modulo QDEPTH.
REQ-026 imem_resp SHALL be 0 and imem_rdata SHALL hold last value in cycles with no response.

Reset
REQ-027 rst SHALL asynchronously clear queue (occupancy 0, pointers 0), imem_resp=0, imem_rdata=0, all err_* =0.
REQ-028 Requests pending at reset SHALL be discarded; no response SHALL appear for them after rst deasserts.
REQ-029 Backing-store contents SHALL NOT be reset.
REQ-030 Requests presented while rst=1 SHALL be ignored.

Structure
REQ-031 Queue-entry struct typedef SHALL live in rv32i_types; NOP constant 32'h00000013 SHALL be added there.
REQ-032 Queue SHALL be a sub-module imem_resp_queue (push/pop/full/empty, entry array, countdown logic); top holds array, response registers, error flags.

Verification
REQ-033 Preload mem[0]=32'hdeadbeef; request 32'h1eceb000 at cycle 5, LATENCY=2 -> imem_resp=1, rdata=32'hdeadbeef at cycle 7 only.
REQ-034 Requests at 32'h1eceb000,+4,+8 on consecutive cycles -> three consecutive resp pulses, words 0,1,2 in order.
REQ-035 QDEPTH=4, LATENCY=7, 6 consecutive requests -> 5th dropped (err_overflow=1), 6th accepted only if a pop coincides; 4 or 5 responses as computed.
REQ-036 Request 32'h1ecea000 -> rdata=32'h00000013, err_range=1; request 32'h1eceb002 -> rdata=0, err_misaligned=1.
REQ-037 Two requests pending, assert rst asynchronously mid-cycle -> imem_resp=0 immediately, no responses after release, err_* =0.
REQ-038 load_we to word 3 with data 32'h1 in same cycle word 3 response fires (old 32'h2) -> rdata=32'h2; next request returns 32'h1.
